// File: rtl/duck_motion_ctl.sv
// Duck flight controller: spawns a duck on hunt_start, flies it with wall
// bounces until shot or timed out, then drops it (hit) or flies it off the
// top (escape).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   game_enable         - level; low forces IDLE, positions retained
//   hunt_start          - 1-cycle pulse; spawn a duck (IDLE only)
//   duck_hit            - 1-cycle pulse; shot landed (FLY only)
//   duck_xpos/duck_ypos - 12-bit top-left sprite position
//   duck_visible        - duck is drawn (FLY/HIT/FALL/ESCAPE)
//   duck_dir_left       - horizontal direction is left (sprite flip)
//   duck_falling        - high in HIT and FALL
//   duck_down           - 1-cycle pulse; shot duck reached the ground
//   duck_escaped        - 1-cycle pulse; duck left through the top
module duck_motion_ctl #(
  parameter int unsigned H_RES     = 1024,
  parameter int unsigned DUCK_W    = 64,
  parameter int unsigned DUCK_H    = 64,
  parameter int unsigned GROUND_Y  = 600,
  parameter int unsigned SPEED     = 4,
  parameter int unsigned STEP_DIV  = 650_000,
  parameter int unsigned FLY_STEPS = 800,
  parameter int unsigned HIT_HOLD  = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        game_enable,
  input  logic        hunt_start,
  input  logic        duck_hit,
  output logic [11:0] duck_xpos,
  output logic [11:0] duck_ypos,
  output logic        duck_visible,
  output logic        duck_dir_left,
  output logic        duck_falling,
  output logic        duck_down,
  output logic        duck_escaped
);

  localparam int unsigned X_MAX  = H_RES - DUCK_W;
  localparam int unsigned Y_MAX  = GROUND_Y - DUCK_H;
  localparam int unsigned STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  // fly_cnt is at least 6 bits so its low bits can mark every 64th tick
  localparam int unsigned FLY_W  = ($clog2(FLY_STEPS) > 6) ? $clog2(FLY_STEPS) : 6;
  localparam int unsigned HOLD_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

  localparam logic signed [12:0] X_MAX_S = 13'(X_MAX);
  localparam logic signed [12:0] Y_MAX_S = 13'(Y_MAX);
  localparam logic signed [12:0] Y_MIN_S = 13'(0);
  localparam logic signed [12:0] SPD_S   = 13'(SPEED);
  localparam logic signed [12:0] DROP_S  = 13'(2 * SPEED);

  typedef enum logic [2:0] {IDLE, FLY, HIT, FALL, ESCAPE} state_t;

  state_t              state;
  logic [15:0]         lfsr;
  logic                dir_up;
  logic [STEP_W-1:0]   step_cnt;
  logic [FLY_W-1:0]    fly_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                tick;
  logic                fly_last;
  logic                hold_last;
  logic                lfsr_fb;
  logic signed [12:0]  xs;
  logic signed [12:0]  ys;
  logic [11:0]         x_next;
  logic [11:0]         y_next;
  logic                dl_next;
  logic                du_next;
  logic                y_wall;
  logic                fall_done;
  logic [11:0]         fall_y;
  logic                esc_done;
  logic [11:0]         esc_y;

  assign tick      = (step_cnt == STEP_W'(STEP_DIV - 1));
  assign fly_last  = (fly_cnt == FLY_W'(FLY_STEPS - 1));
  assign hold_last = (hold_cnt == HOLD_W'(HIT_HOLD - 1));
  assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Next position candidates, computed signed and one bit wider so no wrap
  always_comb begin
    xs        = $signed({1'b0, duck_xpos});
    ys        = $signed({1'b0, duck_ypos});
    x_next    = duck_xpos;
    y_next    = duck_ypos;
    dl_next   = duck_dir_left;
    du_next   = dir_up;
    y_wall    = 1'b0;
    fall_done = 1'b0;
    fall_y    = duck_ypos;
    esc_done  = 1'b0;
    esc_y     = duck_ypos;

    if (duck_dir_left) begin
      if (xs < SPD_S) begin
        x_next  = 12'd0;
        dl_next = 1'b0;
      end else begin
        x_next = 12'(xs - SPD_S);
      end
    end else begin
      if (xs + SPD_S > X_MAX_S) begin
        x_next  = 12'(X_MAX_S);
        dl_next = 1'b1;
      end else begin
        x_next = 12'(xs + SPD_S);
      end
    end

    if (dir_up) begin
      if (ys - SPD_S < Y_MIN_S) begin
        y_next  = 12'(Y_MIN_S);
        du_next = 1'b0;
        y_wall  = 1'b1;
      end else begin
        y_next = 12'(ys - SPD_S);
      end
    end else begin
      if (ys + SPD_S > Y_MAX_S) begin
        y_next  = 12'(Y_MAX_S);
        du_next = 1'b1;
        y_wall  = 1'b1;
      end else begin
        y_next = 12'(ys + SPD_S);
      end
    end

    // Random vertical re-roll every 64th tick; a wall bounce takes priority
    if ((fly_cnt[5:0] == 6'd63) && !y_wall) begin
      du_next = lfsr[0];
    end

    if (ys + DROP_S >= Y_MAX_S) begin
      fall_done = 1'b1;
      fall_y    = 12'(Y_MAX_S);
    end else begin
      fall_y = 12'(ys + DROP_S);
    end

    if (ys < DROP_S) begin
      esc_done = 1'b1;
      esc_y    = 12'd0;
    end else begin
      esc_y = 12'(ys - DROP_S);
    end
  end

  // Flight state machine with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lfsr          <= 16'hACE1;
      dir_up        <= 1'b0;
      step_cnt      <= '0;
      fly_cnt       <= '0;
      hold_cnt      <= '0;
      duck_xpos     <= 12'd0;
      duck_ypos     <= 12'd0;
      duck_visible  <= 1'b0;
      duck_dir_left <= 1'b0;
      duck_falling  <= 1'b0;
      duck_down     <= 1'b0;
      duck_escaped  <= 1'b0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr_fb};
      duck_down    <= 1'b0;
      duck_escaped <= 1'b0;
      step_cnt     <= tick ? '0 : step_cnt + STEP_W'(1);

      if (!game_enable) begin
        // Abort silently: no pulses, position kept for the draw stage
        state        <= IDLE;
        duck_visible <= 1'b0;
        duck_falling <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (hunt_start) begin
              state         <= FLY;
              duck_xpos     <= 12'd256 + 12'(lfsr[8:0]);
              duck_ypos     <= 12'(Y_MAX);
              duck_dir_left <= lfsr[9];
              dir_up        <= 1'b1;
              fly_cnt       <= '0;
              step_cnt      <= '0;
              duck_visible  <= 1'b1;
              duck_falling  <= 1'b0;
            end
          end
          FLY: begin
            // A hit beats a coincident timeout tick and freezes position
            if (duck_hit) begin
              state        <= HIT;
              duck_falling <= 1'b1;
              hold_cnt     <= '0;
            end else if (tick) begin
              duck_xpos     <= x_next;
              duck_ypos     <= y_next;
              duck_dir_left <= dl_next;
              dir_up        <= du_next;
              fly_cnt       <= fly_cnt + FLY_W'(1);
              if (fly_last) begin
                state <= ESCAPE;
              end
            end
          end
          HIT: begin
            if (tick) begin
              if (hold_last) begin
                state <= FALL;
              end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
              end
            end
          end
          FALL: begin
            if (tick) begin
              duck_ypos <= fall_y;
              if (fall_done) begin
                state        <= IDLE;
                duck_visible <= 1'b0;
                duck_falling <= 1'b0;
                duck_down    <= 1'b1;
              end
            end
          end
          ESCAPE: begin
            if (tick) begin
              duck_ypos <= esc_y;
              if (esc_done) begin
                state        <= IDLE;
                duck_visible <= 1'b0;
                duck_escaped <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_duck_motion_ctl.sv
// Scoreboard bench for duck_motion_ctl: stimulus pushes cycle-stamped
// expected output snapshots; a negedge monitor pops and compares them.
module tb_duck_motion_ctl;

  localparam int unsigned H_RES     = 840;
  localparam int unsigned DUCK_W    = 64;
  localparam int unsigned DUCK_H    = 64;
  localparam int unsigned GROUND_Y  = 600;
  localparam int unsigned SPEED     = 4;
  localparam int unsigned STEP_DIV  = 4;
  localparam int unsigned FLY_STEPS = 20;
  localparam int unsigned HIT_HOLD  = 3;

  localparam int XMAX = 776;  // 840 - 64
  localparam int YMAX = 536;  // 600 - 64

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        game_enable = 1'b0;
  logic        hunt_start = 1'b0;
  logic        duck_hit = 1'b0;
  logic [11:0] duck_xpos;
  logic [11:0] duck_ypos;
  logic        duck_visible;
  logic        duck_dir_left;
  logic        duck_falling;
  logic        duck_down;
  logic        duck_escaped;

  duck_motion_ctl #(
    .H_RES(H_RES), .DUCK_W(DUCK_W), .DUCK_H(DUCK_H), .GROUND_Y(GROUND_Y),
    .SPEED(SPEED), .STEP_DIV(STEP_DIV), .FLY_STEPS(FLY_STEPS), .HIT_HOLD(HIT_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_enable(game_enable),
    .hunt_start(hunt_start), .duck_hit(duck_hit),
    .duck_xpos(duck_xpos), .duck_ypos(duck_ypos),
    .duck_visible(duck_visible), .duck_dir_left(duck_dir_left),
    .duck_falling(duck_falling), .duck_down(duck_down),
    .duck_escaped(duck_escaped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR: left-shift Fibonacci, taps 16,14,13,11
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct packed {
    int          cyc;
    logic [79:0] name;
    logic [11:0] x;
    logic [11:0] y;
    logic        vis;
    logic        dl;
    logic        fall;
    logic        down;
    logic        esc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   n_down = 0;
  int   n_esc = 0;

  task automatic expect_at(input int c, input logic [79:0] nm, input int x, input int y,
                           input logic vis, input logic dl, input logic fall,
                           input logic down, input logic esc);
    exp_t e;
    int   i;
    e.cyc = c; e.name = nm; e.x = 12'(x); e.y = 12'(y);
    e.vis = vis; e.dl = dl; e.fall = fall; e.down = down; e.esc = esc;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  // Horizontal flight after k ticks from a spawn, with wall clamp and bounce
  function automatic void fly_x(input int x0, input logic dl0, input int k,
                                output int x, output logic dl);
    x = x0; dl = dl0;
    for (int i = 0; i < k; i++) begin
      if (dl) begin
        if (x < 4) begin x = 0; dl = 1'b0; end
        else x = x - 4;
      end else begin
        if (x + 4 > XMAX) begin x = XMAX; dl = 1'b1; end
        else x = x + 4;
      end
    end
  endfunction

  task automatic expect_fly(input int h, input int x0, input logic dl0, input int k,
                            input logic [79:0] nm);
    int   x;
    logic dl;
    fly_x(x0, dl0, k, x, dl);
    expect_at(h + 4 * k, nm, x, YMAX - 4 * k, 1'b1, dl, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge clk) begin
    if (duck_down) n_down++;
    if (duck_escaped) n_esc++;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      tests++;
      if (mon_e.cyc != cyc) begin
        fails++;
        $display("FAIL %0s: expectation for cycle %0d reached only at cycle %0d",
                 mon_e.name, mon_e.cyc, cyc);
      end else if ({duck_xpos, duck_ypos, duck_visible, duck_dir_left, duck_falling,
                    duck_down, duck_escaped} !==
                   {mon_e.x, mon_e.y, mon_e.vis, mon_e.dl, mon_e.fall, mon_e.down, mon_e.esc}) begin
        fails++;
        $display("FAIL %0s cyc=%0d: got x=%0d y=%0d vis=%b dl=%b fall=%b down=%b esc=%b; want x=%0d y=%0d vis=%b dl=%b fall=%b down=%b esc=%b",
                 mon_e.name, cyc, duck_xpos, duck_ypos, duck_visible, duck_dir_left,
                 duck_falling, duck_down, duck_escaped, mon_e.x, mon_e.y, mon_e.vis,
                 mon_e.dl, mon_e.fall, mon_e.down, mon_e.esc);
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Wait (bounded) for an LFSR value giving the wanted spawn direction/offset
  task automatic wait_spawn(input logic want_left, input int min_off, input logic [79:0] nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (m_lfsr[9] == want_left && int'(m_lfsr[8:0]) >= min_off) ok = 1'b1;
      else @(negedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %0s: no suitable spawn value within 4000 cycles, lfsr=%h", nm, m_lfsr);
    end
  endtask

  int   h, h2, h3, h4, h5;
  int   x0, x1, x3, x4, x5, xa, xe;
  logic d0, d1, d3, d4, d5, da, de;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles, then released
    @(negedge clk);
    expect_at(cyc + 1, "rst_hold", 0, 0, 0, 0, 0, 0, 0);
    goto(3);
    rst_n = 1'b1;
    expect_at(4, "rst_rel", 0, 0, 0, 0, 0, 0, 0);
    game_enable = 1'b1;
    goto(5);

    // A: left-moving spawn, stray hunt_start, hit, hold, fall to ground
    wait_spawn(1'b1, 0, "scan_a");
    h = cyc + 1; x0 = 256 + int'(m_lfsr[8:0]); d0 = m_lfsr[9];
    hunt_start = 1'b1;
    expect_at(h, "spawn", x0, YMAX, 1, d0, 0, 0, 0);
    expect_at(h + 3, "pre_tick", x0, YMAX, 1, d0, 0, 0, 0);
    expect_fly(h, x0, d0, 1, "tick1");
    expect_fly(h, x0, d0, 2, "tick2");
    expect_fly(h, x0, d0, 3, "no_respawn");
    expect_fly(h, x0, d0, 6, "tick6");
    fly_x(x0, d0, 6, xa, da);
    expect_at(h + 26, "hit", xa, 512, 1, da, 1, 0, 0);
    expect_at(h + 36, "hit_hold", xa, 512, 1, da, 1, 0, 0);
    expect_at(h + 40, "fall1", xa, 520, 1, da, 1, 0, 0);
    expect_at(h + 44, "fall2", xa, 528, 1, da, 1, 0, 0);
    expect_at(h + 48, "down", xa, YMAX, 0, da, 0, 1, 0);
    goto(h);
    hunt_start = 1'b0;
    goto(h + 9);
    hunt_start = 1'b1;
    goto(h + 10);
    hunt_start = 1'b0;
    goto(h + 25);
    duck_hit = 1'b1;
    goto(h + 26);
    duck_hit = 1'b0;

    // B: hunt_start during the duck_down cycle respawns; then disable mid-FLY
    goto(h + 48);
    h2 = h + 49; x1 = 256 + int'(m_lfsr[8:0]); d1 = m_lfsr[9];
    hunt_start = 1'b1;
    expect_at(h2, "respawn", x1, YMAX, 1, d1, 0, 0, 0);
    expect_fly(h2, x1, d1, 1, "b_tick1");
    goto(h2);
    hunt_start = 1'b0;
    fly_x(x1, d1, 1, xa, da);
    goto(h2 + 5);
    game_enable = 1'b0;
    expect_at(h2 + 6, "disable", xa, 532, 0, da, 0, 0, 0);
    goto(h2 + 6);
    hunt_start = 1'b1;
    goto(h2 + 7);
    hunt_start = 1'b0;
    expect_at(h2 + 12, "dis_hold", xa, 532, 0, da, 0, 0, 0);
    goto(h2 + 12);
    game_enable = 1'b1;
    goto(h2 + 14);

    // C: right-moving spawn near the wall, bounce, timeout, escape
    wait_spawn(1'b0, 448, "scan_c");
    h3 = cyc + 1; x3 = 256 + int'(m_lfsr[8:0]); d3 = m_lfsr[9];
    hunt_start = 1'b1;
    expect_at(h3, "c_spawn", x3, YMAX, 1, d3, 0, 0, 0);
    for (int k = 1; k <= 20; k++) expect_fly(h3, x3, d3, k, "c_tick");
    fly_x(x3, d3, 20, xe, de);
    expect_at(h3 + 84, "esc1", xe, 448, 1, de, 0, 0, 0);
    expect_at(h3 + 92, "esc_hit", xe, 432, 1, de, 0, 0, 0);
    expect_at(h3 + 308, "esc_top", xe, 0, 1, de, 0, 0, 0);
    expect_at(h3 + 312, "escaped", xe, 0, 0, de, 0, 0, 1);
    expect_at(h3 + 313, "post_esc", xe, 0, 0, de, 0, 0, 0);
    goto(h3);
    hunt_start = 1'b0;
    goto(h3 + 89);
    duck_hit = 1'b1;
    goto(h3 + 90);
    duck_hit = 1'b0;

    // D: reset mid-flight, then the reseeded LFSR drives the next spawn
    goto(h3 + 320);
    h4 = cyc + 1; x4 = 256 + int'(m_lfsr[8:0]); d4 = m_lfsr[9];
    hunt_start = 1'b1;
    expect_at(h4, "d_spawn", x4, YMAX, 1, d4, 0, 0, 0);
    expect_fly(h4, x4, d4, 1, "d_tick1");
    goto(h4);
    hunt_start = 1'b0;
    goto(h4 + 5);
    rst_n = 1'b0;
    expect_at(h4 + 6, "rst_mid", 0, 0, 0, 0, 0, 0, 0);
    goto(h4 + 7);
    rst_n = 1'b1;
    goto(h4 + 9);
    h5 = cyc + 1; x5 = 256 + int'(m_lfsr[8:0]); d5 = m_lfsr[9];
    hunt_start = 1'b1;
    expect_at(h5, "e_spawn", x5, YMAX, 1, d5, 0, 0, 0);
    expect_fly(h5, x5, d5, 1, "e_tick1");
    goto(h5);
    hunt_start = 1'b0;
    goto(h5 + 6);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
    end
    tests++;
    if (n_down != 1) begin
      fails++;
      $display("FAIL down_count: got %0d duck_down cycles, want 1", n_down);
    end
    tests++;
    if (n_esc != 1) begin
      fails++;
      $display("FAIL esc_count: got %0d duck_escaped cycles, want 1", n_esc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
